// File: rtl/scale_mode_controller.sv
// Scale mode controller for the camera upscaling datapath.
// Gesture zoom requests are turned into a registered 2-bit scale select.
// The select only moves on a frame boundary, so a frame never mixes scales.
// After each change, requests are ignored for a number of frames so that
// gesture chatter cannot cause a run of changes.
`timescale 1ns/1ps

module scale_mode_controller #(
    parameter int COOLDOWN_FRAMES = 30,
    parameter int RESET_LEVEL     = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       up_in,
    input  logic       down_in,
    input  logic       frame_start_in,
    output logic [1:0] scale_out,
    output logic       changed_out,
    output logic       busy_out
);

    // The cooldown counter must hold COOLDOWN_FRAMES; a zero cooldown still
    // gets one bit so the register stays legal.
    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]       LEVEL_RESET = 2'(RESET_LEVEL);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COOLDOWN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       level;
    logic [1:0]       level_next;
    logic [1:0]       target;
    logic [1:0]       target_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             changed_next;

    // Zoom level to scaler select: 0 -> 1X, 1 -> 2Hx2V, 2 -> 4Hx2V.
    // 2'b01 is never produced.
    function automatic logic [1:0] level_to_scale(input logic [1:0] lvl);
        logic [1:0] sel;
        case (lvl)
            2'd0:    sel = 2'b00;
            2'd1:    sel = 2'b11;
            default: sel = 2'b10;
        endcase
        return sel;
    endfunction

    // Next-state logic: accept requests in IDLE, commit on a frame start in
    // PENDING, and count frame starts down in COOLDOWN.
    always_comb begin
        state_next   = state;
        level_next   = level;
        target_next  = target;
        cnt_next     = cnt;
        changed_next = 1'b0;
        case (state)
            IDLE: begin
                // A request that would step past either end is dropped.
                // A request that arrives together with a frame start is only
                // latched here; it is applied at the following frame start.
                if (up_in && !down_in) begin
                    if (level != 2'd2) begin
                        target_next = level + 2'd1;
                        state_next  = PENDING;
                    end
                end else if (down_in && !up_in) begin
                    if (level != 2'd0) begin
                        target_next = level - 2'd1;
                        state_next  = PENDING;
                    end
                end
            end
            PENDING: begin
                if (frame_start_in) begin
                    level_next   = target;
                    changed_next = 1'b1;
                    cnt_next     = CNT_LOAD;
                    state_next   = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                end
            end
            COOLDOWN: begin
                // The counter never goes below zero; the last counted frame
                // start returns to IDLE.
                if (frame_start_in) begin
                    if (cnt <= CNT_ONE) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any pending or cooldown work
    // without producing a change pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            level       <= LEVEL_RESET;
            target      <= LEVEL_RESET;
            cnt         <= '0;
            scale_out   <= level_to_scale(LEVEL_RESET);
            changed_out <= 1'b0;
        end else begin
            state       <= state_next;
            level       <= level_next;
            target      <= target_next;
            cnt         <= cnt_next;
            scale_out   <= level_to_scale(level_next);
            changed_out <= changed_next;
        end
    end

    assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_scale_mode_controller.sv
// Bench for scale_mode_controller: three instances with different cooldown
// and reset settings share one stimulus stream and are compared each cycle
// against a frame-counting reference model.
`timescale 1ns/1ps

module tb_scale_mode_controller;

    logic clk = 1'b0;
    logic rst;
    logic up;
    logic down;
    logic fs;

    logic [1:0] scale   [3];
    logic       changed [3];
    logic       busy    [3];

    int total = 0;
    int bad   = 0;

    // Per-instance settings: cooldown frames and reset level.
    int cd [3] = '{3, 0, 30};
    int rl [3] = '{0, 0, 2};

    // Reference model: current zoom level, requested level (-1 = none),
    // frames still to wait before requests count again, and change pulse.
    int         m_level   [3];
    int         m_pend    [3];
    int         m_cool    [3];
    int         m_changed [3];
    logic [1:0] scale_of  [3] = '{2'b00, 2'b11, 2'b10};

    always #5 clk = ~clk;

    scale_mode_controller #(.COOLDOWN_FRAMES(3), .RESET_LEVEL(0)) dut_a (
        .clk_in(clk), .rst_in(rst), .up_in(up), .down_in(down), .frame_start_in(fs),
        .scale_out(scale[0]), .changed_out(changed[0]), .busy_out(busy[0])
    );

    scale_mode_controller #(.COOLDOWN_FRAMES(0), .RESET_LEVEL(0)) dut_b (
        .clk_in(clk), .rst_in(rst), .up_in(up), .down_in(down), .frame_start_in(fs),
        .scale_out(scale[1]), .changed_out(changed[1]), .busy_out(busy[1])
    );

    scale_mode_controller #(.COOLDOWN_FRAMES(30), .RESET_LEVEL(2)) dut_c (
        .clk_in(clk), .rst_in(rst), .up_in(up), .down_in(down), .frame_start_in(fs),
        .scale_out(scale[2]), .changed_out(changed[2]), .busy_out(busy[2])
    );

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            m_level[i]   = rl[i];
            m_pend[i]    = -1;
            m_cool[i]    = 0;
            m_changed[i] = 0;
        end
    endtask

    task automatic modelStep(input logic u, input logic d, input logic f);
        int t;
        for (int i = 0; i < 3; i++) begin
            m_changed[i] = 0;
            if (m_pend[i] >= 0) begin
                if (f) begin
                    m_level[i]   = m_pend[i];
                    m_pend[i]    = -1;
                    m_changed[i] = 1;
                    m_cool[i]    = cd[i];
                end
            end else if (m_cool[i] > 0) begin
                if (f) m_cool[i] = m_cool[i] - 1;
            end else if (u != d) begin
                t = m_level[i] + (u ? 1 : -1);
                if (t >= 0 && t <= 2) m_pend[i] = t;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0] exp_scale;
        logic       exp_busy;
        logic       exp_changed;
        for (int i = 0; i < 3; i++) begin
            exp_scale   = scale_of[m_level[i]];
            exp_busy    = (m_pend[i] >= 0) || (m_cool[i] > 0);
            exp_changed = (m_changed[i] != 0);
            total++;
            assert (scale[i] === exp_scale) else begin
                bad++;
                $error("[TB] FAIL %s dut%0d scale_out got=%b exp=%b", tag, i, scale[i], exp_scale);
            end
            total++;
            assert (busy[i] === exp_busy) else begin
                bad++;
                $error("[TB] FAIL %s dut%0d busy_out got=%b exp=%b", tag, i, busy[i], exp_busy);
            end
            total++;
            assert (changed[i] === exp_changed) else begin
                bad++;
                $error("[TB] FAIL %s dut%0d changed_out got=%b exp=%b", tag, i, changed[i], exp_changed);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check
    // the outputs just after the edge.
    task automatic applyStimulus(input logic u, input logic d, input logic f, input string tag);
        up   = u;
        down = d;
        fs   = f;
        @(posedge clk);
        modelStep(u, d, f);
        #1;
        checkOutput(tag);
        up   = 1'b0;
        down = 1'b0;
        fs   = 1'b0;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        up   = 1'b0;
        down = 1'b0;
        fs   = 1'b0;
        modelReset();

        $display("[TB] reset state");
        doReset();

        $display("[TB] first zoom in, applied at the frame start");
        applyStimulus(1'b1, 1'b0, 1'b0, "up1");
        idleCycles(4, "wait1");
        applyStimulus(1'b0, 1'b0, 1'b1, "fs_apply1");
        idleCycles(2, "after1");

        $display("[TB] cooldown window");
        applyStimulus(1'b0, 1'b0, 1'b1, "cool_fs1");
        idleCycles(1, "cool_gap");
        applyStimulus(1'b0, 1'b0, 1'b1, "cool_fs2");
        applyStimulus(1'b1, 1'b0, 1'b0, "up_in_cool");
        idleCycles(1, "cool_gap2");
        applyStimulus(1'b0, 1'b0, 1'b1, "cool_fs3");
        applyStimulus(1'b1, 1'b0, 1'b0, "up_after_cool");
        idleCycles(2, "wait2");
        applyStimulus(1'b0, 1'b0, 1'b1, "fs_apply2");
        idleCycles(1, "after2");

        $display("[TB] saturation at both ends");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, "drain_fs");
            idleCycles(1, "drain_gap");
        end
        applyStimulus(1'b1, 1'b0, 1'b0, "up_at_top");
        idleCycles(2, "top_hold");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, "down_at_bottom");
        idleCycles(2, "bottom_hold");
        applyStimulus(1'b0, 1'b0, 1'b1, "bottom_fs");

        $display("[TB] simultaneous requests and frame-start collision");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, "both_req");
        idleCycles(1, "both_hold");
        applyStimulus(1'b0, 1'b0, 1'b1, "both_fs");
        applyStimulus(1'b1, 1'b0, 1'b1, "up_with_fs");
        idleCycles(3, "collide_wait");
        applyStimulus(1'b0, 1'b0, 1'b1, "collide_apply");
        idleCycles(1, "collide_after");

        $display("[TB] asynchronous reset while pending");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, "up_before_rst");
        idleCycles(1, "pending");
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst");
        #3;
        rst = 1'b0;
        @(posedge clk);
        modelStep(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("post_rst");
        applyStimulus(1'b0, 1'b0, 1'b1, "fs_after_rst");
        idleCycles(1, "post_rst_hold");

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 5) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
